regfile_param: RTL and testbench

Parametrised register file for the LEGv8 datapath with a configurable hard-wired zero register and two combinational read ports. It has one synchronous write port with optional write-to-read bypass and a per-register pending-write scoreboard for pipelined load-use detection. A built-in init sequencer loads a known register image after reset. It replaces the fixed 32x64 register file in the decode stage.

---
 rtl/regfile_param.sv | 112 +++++++++++
 tb/tb_regfile_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised LEGv8 register file: hard-wired zero register, two combinational read ports,
// one write port with optional bypass, pending-write scoreboard and a post-reset init sequencer.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_INIT | loading register image, one register per cycle; I/O locked
// S_RUN  | normal read/write/claim operation
module regfile_param #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 31,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we3,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              pend1,
    output logic              pend2,
    output logic              init_busy
);
    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic [0:0]        S_INIT = 1'b0;
    localparam logic [0:0]        S_RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic busy;
    logic wr_ok;
    logic hit1, hit2;

    // Reset is folded in so outputs are forced quiet before the first reset edge lands.
    assign busy      = reset || (state_q == S_INIT);
    assign init_busy = busy;
    assign wr_ok     = !busy && we3 && (wa3 != ZERO_A);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_A) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        end
    end

    // Set wins over clear when claim and write hit the same register.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wa3] = 1'b0;
        end
        if (!busy && claim_en && (claim_addr != ZERO_A)) begin
            pend_d[claim_addr] = 1'b1;
        end
        pend_d[ZERO_A] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Storage has no reset; its contents are defined by the init sequence.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_INIT) begin
            regs_q[cnt_q] <= (INIT_MODE != 0) ? DATA_W'(cnt_q) : '0;
        end else if (wr_ok) begin
            regs_q[wa3] <= wd3;
        end
    end

    assign hit1 = (BYPASS != 0) && we3 && (wa3 == ra1);
    assign hit2 = (BYPASS != 0) && we3 && (wa3 == ra2);

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!busy && ra1 != ZERO_A) begin
            rd1 = hit1 ? wd3 : regs_q[ra1];
        end
        if (!busy && ra2 != ZERO_A) begin
            rd2 = hit2 ? wd3 : regs_q[ra2];
        end
    end

    assign pend1 = !busy && !hit1 && pend_q[ra1];
    assign pend2 = !busy && !hit2 && pend_q[ra2];

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: three instances (default, no-bypass, zero-init) share stimulus.
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, wa3, claim_addr;
    logic [63:0] wd3;
    logic        we3, claim_en;

    logic [63:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
    logic        pend1_a, pend2_a, pend1_b, pend2_b, pend1_c, pend2_c;
    logic        busy_a, busy_b, busy_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_param #(.INIT_MODE(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .wa3(wa3), .wd3(wd3), .we3(we3), .claim_en(claim_en), .claim_addr(claim_addr),
        .pend1(pend1_a), .pend2(pend2_a), .init_busy(busy_a));

    regfile_param #(.INIT_MODE(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .wa3(wa3), .wd3(wd3), .we3(we3), .claim_en(claim_en), .claim_addr(claim_addr),
        .pend1(pend1_b), .pend2(pend2_b), .init_busy(busy_b));

    regfile_param #(.INIT_MODE(0), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_c), .rd2(rd2_c),
        .wa3(wa3), .wd3(wd3), .we3(we3), .claim_en(claim_en), .claim_addr(claim_addr),
        .pend1(pend1_c), .pend2(pend2_c), .init_busy(busy_c));

    // Counts edges after reset release until init_busy drops; 100 means it never did.
    task automatic wait_init(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy_a) break;
        end
    endtask

    task automatic idle_inputs();
        we3 = 1'b0; wa3 = '0; wd3 = '0; claim_en = 1'b0; claim_addr = '0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; idle_inputs(); ra1 = 5'd5; ra2 = 5'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || rd1_a !== 64'd0 || pend1_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%0b rd1=%0h pend1=%0b, required busy=1 rd1=0 pend1=0",
                     busy_a, rd1_a, pend1_a);
        end
        reset = 1'b0;
        wait_init(n);
        checks++;
        if (n !== 32) begin
            failures++;
            $display("FAIL init_duration: busy cycles=%0d, required 32", n);
        end
        @(negedge clk);
        ra1 = 5'd5; ra2 = 5'd30; #1;
        checks++;
        if (rd1_a !== 64'd5 || rd2_a !== 64'd30) begin
            failures++;
            $display("FAIL init_image: rd1=%0h rd2=%0h, required 5 and 1e", rd1_a, rd2_a);
        end
        checks++;
        if (rd1_c !== 64'd0) begin
            failures++;
            $display("FAIL init_zero_mode: rd1=%0h, required 0", rd1_c);
        end
        ra1 = 5'd31; #1;
        checks++;
        if (rd1_a !== 64'd0) begin
            failures++;
            $display("FAIL zero_reg_read: rd1=%0h, required 0", rd1_a);
        end
    endtask

    task automatic test_write_zero();
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hDEAD_BEEF;
        @(negedge clk);
        we3 = 1'b0; ra1 = 5'd7; ra2 = 5'd6; #1;
        checks++;
        if (rd1_a !== 64'hDEAD_BEEF || rd1_b !== 64'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_read: rd1_a=%0h rd1_b=%0h, required deadbeef", rd1_a, rd1_b);
        end
        checks++;
        if (rd2_a !== 64'd6) begin
            failures++;
            $display("FAIL neighbour_untouched: rd2=%0h, required 6", rd2_a);
        end
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'd1; ra1 = 5'd31; #1;
        checks++;
        if (rd1_a !== 64'd0) begin
            failures++;
            $display("FAIL zero_reg_bypass: rd1=%0h, required 0", rd1_a);
        end
        @(negedge clk);
        we3 = 1'b0; #1;
        checks++;
        if (rd1_a !== 64'd0 || rd1_b !== 64'd0) begin
            failures++;
            $display("FAIL zero_reg_write: rd1_a=%0h rd1_b=%0h, required 0", rd1_a, rd1_b);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        ra1 = 5'd9; we3 = 1'b1; wa3 = 5'd9; wd3 = 64'd123; #1;
        checks++;
        if (rd1_a !== 64'd123) begin
            failures++;
            $display("FAIL bypass_on: rd1=%0d, required 123", rd1_a);
        end
        checks++;
        if (rd1_b !== 64'd9) begin
            failures++;
            $display("FAIL bypass_off_same: rd1=%0d, required 9", rd1_b);
        end
        @(negedge clk);
        we3 = 1'b0; #1;
        checks++;
        if (rd1_b !== 64'd123 || rd1_a !== 64'd123) begin
            failures++;
            $display("FAIL bypass_off_next: rd1_b=%0d rd1_a=%0d, required 123", rd1_b, rd1_a);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        claim_en = 1'b1; claim_addr = 5'd4; ra2 = 5'd4;
        @(negedge clk);
        claim_en = 1'b0; #1;
        checks++;
        if (pend2_a !== 1'b1 || pend2_b !== 1'b1) begin
            failures++;
            $display("FAIL claim_sets: pend2_a=%0b pend2_b=%0b, required 1", pend2_a, pend2_b);
        end
        we3 = 1'b1; wa3 = 5'd4; wd3 = 64'd44; #1;
        checks++;
        if (pend2_a !== 1'b0 || pend2_b !== 1'b1) begin
            failures++;
            $display("FAIL pend_mask_same: pend2_a=%0b pend2_b=%0b, required 0 and 1", pend2_a, pend2_b);
        end
        @(negedge clk);
        we3 = 1'b0; #1;
        checks++;
        if (pend2_a !== 1'b0 || pend2_b !== 1'b0 || rd2_a !== 64'd44) begin
            failures++;
            $display("FAIL write_clears: pend2_a=%0b pend2_b=%0b rd2=%0d, required 0 0 44",
                     pend2_a, pend2_b, rd2_a);
        end
        we3 = 1'b1; wa3 = 5'd4; wd3 = 64'd55; claim_en = 1'b1; claim_addr = 5'd4;
        @(negedge clk);
        we3 = 1'b0; claim_en = 1'b0; #1;
        checks++;
        if (pend2_a !== 1'b1 || rd2_a !== 64'd55) begin
            failures++;
            $display("FAIL set_wins: pend2=%0b rd2=%0d, required 1 55", pend2_a, rd2_a);
        end
        claim_en = 1'b1; claim_addr = 5'd31; ra1 = 5'd31;
        @(negedge clk);
        claim_en = 1'b0; #1;
        checks++;
        if (pend1_a !== 1'b0 || pend1_b !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg_claim: pend1_a=%0b pend1_b=%0b, required 0", pend1_a, pend1_b);
        end
    endtask

    task automatic test_reset_run();
        int n;
        ra2 = 5'd4;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_init(n);
        checks++;
        if (n !== 32) begin
            failures++;
            $display("FAIL run_reset_duration: busy cycles=%0d, required 32", n);
        end
        #1;
        checks++;
        if (pend2_a !== 1'b0 || rd2_a !== 64'd4 || rd2_c !== 64'd0) begin
            failures++;
            $display("FAIL run_reset_state: pend2=%0b rd2_a=%0d rd2_c=%0d, required 0 4 0",
                     pend2_a, rd2_a, rd2_c);
        end
    endtask

    task automatic test_init_lockout();
        int n;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'hFF; claim_en = 1'b1; claim_addr = 5'd3;
        wait_init(n);
        idle_inputs();
        checks++;
        if (n !== 32) begin
            failures++;
            $display("FAIL lockout_duration: busy cycles=%0d, required 32", n);
        end
        @(negedge clk);
        ra1 = 5'd3; #1;
        checks++;
        if (rd1_a !== 64'd3 || pend1_a !== 1'b0) begin
            failures++;
            $display("FAIL init_lockout: rd1=%0h pend1=%0b, required 3 0", rd1_a, pend1_a);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_init_busy: busy=%0b, required 1", busy_a);
        end
        reset = 1'b0;
        wait_init(n);
        checks++;
        if (n !== 32) begin
            failures++;
            $display("FAIL mid_init_restart: busy cycles=%0d, required 32", n);
        end
    endtask

    initial begin
        reset = 1'b1; ra1 = '0; ra2 = '0; idle_inputs();
        test_reset();
        test_write_zero();
        test_bypass();
        test_scoreboard();
        test_reset_run();
        test_init_lockout();
        test_reset_mid_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
